// File: rtl/sample_window_counter.sv
// -----------------------------------------------------------------------------
// sample_window_counter
//
// Counts cnt_up strobes from the sample datapath against a limit that can be
// reloaded at runtime, and flags every completed window with a one-cycle pulse.
// One-shot mode parks in DONE after a window. Continuous mode re-arms itself
// immediately, so a sample arriving on the very next cycle is sample 1 of the
// following window. A saturating count of completed windows, plus a sticky
// overflow flag, is kept for the host/status side.
//
// Parameters
//   CNT_WIDTH      width of the sample count and of the limit register
//   DEFAULT_LIMIT  limit after reset, must lie in 1 .. 2**CNT_WIDTH-1
//   WIN_WIDTH      width of the completed-window counter
//
// Ports
//   i_clk          system clock, all logic on the rising edge
//   i_rst          synchronous reset, active high
//   i_start        arm counting; accepted in IDLE or DONE, ignored in COUNT
//   i_clear        abort the window and return to IDLE; count -> 0
//   i_cnt_up       one sample accepted this cycle
//   i_continuous   1 = auto-restart after a window, 0 = one-shot
//   i_limit_in     new window length
//   i_limit_load   load i_limit_in; honoured in IDLE only, and only if non-zero
//   o_count        samples counted in the current window
//   o_window_done  one-cycle pulse, a window has just completed
//   o_done         level, one-shot window complete (DONE state)
//   o_busy         high in COUNT state
//   o_win_cnt      completed windows since reset, saturating
//   o_win_ovf      sticky, a window completed while o_win_cnt was saturated
//
// Priority within one cycle: i_rst > i_clear > i_start > i_cnt_up.
// Every output comes straight from a register or from decoding the state
// register, so all of them respond on the edge after the causing input.
// -----------------------------------------------------------------------------
module sample_window_counter #(
  parameter int unsigned CNT_WIDTH     = 10,
  parameter int unsigned DEFAULT_LIMIT = 1000,
  parameter int unsigned WIN_WIDTH     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_clear,
  input  logic                 i_cnt_up,
  input  logic                 i_continuous,
  input  logic [CNT_WIDTH-1:0] i_limit_in,
  input  logic                 i_limit_load,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_window_done,
  output logic                 o_done,
  output logic                 o_busy,
  output logic [WIN_WIDTH-1:0] o_win_cnt,
  output logic                 o_win_ovf
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] LimitRst = CNT_WIDTH'(DEFAULT_LIMIT);
  localparam logic [CNT_WIDTH-1:0] CntOne   = CNT_WIDTH'(1);
  localparam logic [WIN_WIDTH-1:0] WinOne   = WIN_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------------
  state_e                 r_state;
  state_e                 w_state_d;
  logic [CNT_WIDTH-1:0]   r_count;
  logic [CNT_WIDTH-1:0]   w_count_d;
  logic [CNT_WIDTH-1:0]   r_limit;
  logic [CNT_WIDTH-1:0]   w_limit_d;
  logic                   r_window_done;
  logic                   w_window_done_d;
  logic [WIN_WIDTH-1:0]   r_win_cnt;
  logic [WIN_WIDTH-1:0]   w_win_cnt_d;
  logic                   r_win_ovf;
  logic                   w_win_ovf_d;

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  logic                   w_in_idle;
  logic                   w_in_count;
  logic                   w_in_done;
  logic [CNT_WIDTH-1:0]   w_limit_m1;
  logic                   w_at_last;
  logic                   w_window_end;
  logic                   w_arm;
  logic                   w_limit_ok;
  logic                   w_win_sat;

  assign w_in_idle  = (r_state == StIdle);
  assign w_in_count = (r_state == StCount);
  assign w_in_done  = (r_state == StDone);

  // The limit is never zero, so limit-1 cannot underflow.
  assign w_limit_m1 = r_limit - CntOne;
  assign w_at_last  = (r_count == w_limit_m1);

  // The limit-th sample closes the window; clear suppresses it completely.
  assign w_window_end = w_in_count & i_cnt_up & w_at_last & ~i_clear;

  // start is only meaningful outside COUNT, and clear beats it.
  assign w_arm = (w_in_idle | w_in_done) & i_start & ~i_clear;

  // A zero limit would make the window unreachable, so it is refused.
  assign w_limit_ok = i_limit_load & (i_limit_in != '0);

  assign w_win_sat = (r_win_cnt == '1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d = r_state;
    if (i_clear) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            w_state_d = StCount;
          end
        end
        StCount: begin
          // continuous only matters on the edge that closes a window.
          if (w_window_end && !i_continuous) begin
            w_state_d = StDone;
          end
        end
        StDone: begin
          if (i_start) begin
            w_state_d = StCount;
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_done        = w_in_done;
    o_busy        = w_in_count;
    o_count       = r_count;
    o_window_done = r_window_done;
    o_win_cnt     = r_win_cnt;
    o_win_ovf     = r_win_ovf;
  end

  // ---------------------------------------------------------------------------
  // Sample count
  // ---------------------------------------------------------------------------
  always_comb begin
    w_count_d = r_count;
    if (i_clear || w_arm) begin
      w_count_d = '0;
    end else if (w_in_count && i_cnt_up) begin
      // Window end folds back to zero instead of reaching the limit, so the
      // count stays within 0 .. limit-1 and never wraps through the top.
      w_count_d = w_at_last ? '0 : (r_count + CntOne);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Limit register
  // ---------------------------------------------------------------------------
  // Loads only while IDLE, so the limit can never move under a running window
  // and the count-below-limit invariant holds. The load is independent of a
  // start or clear in the same cycle; a start alongside it uses the new value.
  always_comb begin
    w_limit_d = r_limit;
    if (w_in_idle && w_limit_ok) begin
      w_limit_d = i_limit_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_limit <= LimitRst;
    end else begin
      r_limit <= w_limit_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Window-complete pulse and window statistics
  // ---------------------------------------------------------------------------
  always_comb begin
    w_window_done_d = w_window_end;
    w_win_cnt_d     = r_win_cnt;
    w_win_ovf_d     = r_win_ovf;
    if (w_window_end) begin
      if (w_win_sat) begin
        w_win_ovf_d = 1'b1;
      end else begin
        w_win_cnt_d = r_win_cnt + WinOne;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_window_done <= 1'b0;
      r_win_cnt     <= '0;
      r_win_ovf     <= 1'b0;
    end else begin
      r_window_done <= w_window_done_d;
      r_win_cnt     <= w_win_cnt_d;
      r_win_ovf     <= w_win_ovf_d;
    end
  end

endmodule

// File: tb/tb_sample_window_counter.sv
// -----------------------------------------------------------------------------
// tb_sample_window_counter
//
// Scoreboarded bench. The driver applies one input vector per clock, advances a
// behavioural model of the window counter and queues the outputs it expects
// after that edge. A separate monitor pops one expectation per falling edge and
// compares every output. WIN_WIDTH is 2 so saturation is reached quickly.
// -----------------------------------------------------------------------------
module tb_sample_window_counter;

  localparam int CW  = 10;
  localparam int DEF = 1000;
  localparam int WW  = 2;
  localparam int WIN_MAX = (1 << WW) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_COUNT = 1;
  localparam int M_DONE  = 2;

  typedef struct {
    int count;
    int wd;
    int done;
    int busy;
    int wc;
    int ovf;
  } exp_t;

  bit            clk;
  logic          rst;
  logic          start;
  logic          clear;
  logic          cnt_up;
  logic          continuous;
  logic [CW-1:0] limit_in;
  logic          limit_load;
  logic [CW-1:0] count;
  logic          window_done;
  logic          done;
  logic          busy;
  logic [WW-1:0] win_cnt;
  logic          win_ovf;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;
  int   cyc;

  // Model: a mode, the number of samples seen in the window, the limit and
  // an unbounded count of completed windows.
  int m_mode;
  int m_count;
  int m_limit;
  int m_wins;

  sample_window_counter #(
    .CNT_WIDTH    (CW),
    .DEFAULT_LIMIT(DEF),
    .WIN_WIDTH    (WW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_clear      (clear),
    .i_cnt_up     (cnt_up),
    .i_continuous (continuous),
    .i_limit_in   (limit_in),
    .i_limit_load (limit_load),
    .o_count      (count),
    .o_window_done(window_done),
    .o_done       (done),
    .o_busy       (busy),
    .o_win_cnt    (win_cnt),
    .o_win_ovf    (win_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, req);
    end
  endtask

  // Monitor: every falling edge, compare the outputs against the oldest
  // outstanding expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cyc++;
      chk("count",       int'(count),       e.count);
      chk("window_done", int'(window_done), e.wd);
      chk("done",        int'(done),        e.done);
      chk("busy",        int'(busy),        e.busy);
      chk("win_cnt",     int'(win_cnt),     e.wc);
      chk("win_ovf",     int'(win_ovf),     e.ovf);
    end
  end

  // Drive one cycle of inputs, advance the model, queue the expected outputs.
  task automatic step(input bit r, input bit c, input bit s, input bit u,
                      input bit cont, input bit ld, input int lim);
    exp_t e;
    int   pre;
    rst        = r;
    clear      = c;
    start      = s;
    cnt_up     = u;
    continuous = cont;
    limit_load = ld;
    limit_in   = CW'(lim);
    pre        = m_mode;
    e.wd       = 0;
    if (r) begin
      m_mode  = M_IDLE;
      m_count = 0;
      m_limit = DEF;
      m_wins  = 0;
    end else begin
      if (c) begin
        m_mode  = M_IDLE;
        m_count = 0;
      end else if (pre == M_COUNT) begin
        if (u) begin
          m_count++;
          if (m_count == m_limit) begin
            m_count = 0;
            e.wd    = 1;
            m_wins++;
            if (!cont) m_mode = M_DONE;
          end
        end
      end else if (s) begin
        m_mode  = M_COUNT;
        m_count = 0;
      end
      if (pre == M_IDLE && ld && lim != 0) m_limit = lim;
    end
    e.count = m_count;
    e.done  = (m_mode == M_DONE) ? 1 : 0;
    e.busy  = (m_mode == M_COUNT) ? 1 : 0;
    e.wc    = (m_wins > WIN_MAX) ? WIN_MAX : m_wins;
    e.ovf   = (m_wins > WIN_MAX) ? 1 : 0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ups(input int n, input bit cont);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, cont, 0, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    m_mode   = M_IDLE;
    m_count  = 0;
    m_limit  = DEF;
    m_wins   = 0;

    // Default limit, one-shot; an extra sample in DONE is ignored.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    ups(DEF, 0);
    ups(1, 0);
    idle(2);

    // Continuous, limit 4, twelve back-to-back samples.
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 4);
    step(0, 0, 1, 0, 1, 0, 0);
    ups(12, 1);

    // clear together with the closing sample.
    ups(3, 1);
    step(0, 1, 0, 1, 1, 0, 0);
    idle(2);

    // Zero load refused in IDLE, load refused in COUNT: window stays DEF.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 7);
    ups(DEF, 0);
    // start from DONE restarts; start in COUNT is ignored.
    step(0, 0, 1, 0, 0, 0, 0);
    ups(2, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    idle(1);

    // Saturation with limit 1: five windows overflow a 2-bit counter.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 1, 0, 0);
    ups(5, 1);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0);

    // Reset mid-window must restore the default limit.
    step(0, 0, 0, 0, 0, 1, 600);
    step(0, 0, 1, 0, 0, 0, 0);
    ups(500, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    ups(DEF, 0);

    // Randomized traffic with short limits so windows close often.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 10),
           ($urandom_range(0, 99) < 65),
           ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 15),
           int'($urandom_range(0, 7)));
    end
    idle(2);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
